// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, FSM encoding and helpers for the fetch stage
package fetch_unit_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) used for IF/ID bubbles.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry pending buffer for responses that arrive while decode is stalled
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [31:0] push_instr_i,
  input  logic [31:0] push_pc_i,
  input  logic        pop_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  // Next entry: clear beats push, push beats pop (push+pop replaces the entry).
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (push_i) begin
      valid_d = 1'b1;
      instr_d = push_instr_i;
      pc_d    = push_pc_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with single-outstanding memory request and IF/ID register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [31:0]  pc_req_q, pc_req_d;
  logic [31:0]  instr_d_q, instr_d_d;
  logic [31:0]  pc_d_q, pc_d_d;
  logic         valid_d_q, valid_d_d;

  logic         pend_valid;
  logic [31:0]  pend_instr;
  logic [31:0]  pend_pc;
  logic         pend_clear, pend_push, pend_pop;
  logic         pend_valid_nx;

  logic         outstanding;
  logic         retire;
  logic         keep;
  logic         issue;
  logic [31:0]  branch_target;

  assign outstanding   = (state_q != ST_IDLE);
  // A strobe seen in IDLE belongs to nothing we asked for (e.g. pre-reset) and is ignored.
  assign retire        = outstanding && imem_rvalid;
  assign keep          = retire && (state_q == ST_WAIT);
  assign branch_target = BranchTargetE & ~32'd3;

  fetch_skid_buf u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pend_clear),
    .push_i       (pend_push),
    .push_instr_i (imem_rdata),
    .push_pc_i    (pc_req_q),
    .pop_i        (pend_pop),
    .valid_o      (pend_valid),
    .instr_o      (pend_instr),
    .pc_o         (pend_pc)
  );

  // Next-state: redirect, IF/ID load/hold/bubble, pending buffer control and request issue.
  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    pc_req_d      = pc_req_q;
    instr_d_d     = instr_d_q;
    pc_d_d        = pc_d_q;
    valid_d_d     = valid_d_q;
    pend_clear    = 1'b0;
    pend_push     = 1'b0;
    pend_pop      = 1'b0;
    pend_valid_nx = pend_valid;
    issue         = 1'b0;

    if (BranchTakenE) begin
      // Redirect wins over everything; whatever is in flight becomes stale.
      valid_d_d  = 1'b0;
      instr_d_d  = NOP_INSTR;
      pend_clear = 1'b1;
      pc_f_d     = branch_target;
      if (retire) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_WAIT) begin
        state_d = ST_DROP;
      end
    end else begin
      if (FlushD) begin
        valid_d_d     = 1'b0;
        instr_d_d     = NOP_INSTR;
        pend_clear    = 1'b1;
        pend_valid_nx = 1'b0;
      end else if (!StallD) begin
        if (pend_valid) begin
          valid_d_d     = 1'b1;
          instr_d_d     = pend_instr;
          pc_d_d        = pend_pc;
          pend_pop      = 1'b1;
          pend_valid_nx = 1'b0;
          if (keep) begin
            pend_push     = 1'b1;
            pend_valid_nx = 1'b1;
          end
        end else if (keep) begin
          valid_d_d = 1'b1;
          instr_d_d = imem_rdata;
          pc_d_d    = pc_req_q;
        end else begin
          valid_d_d = 1'b0;
          instr_d_d = NOP_INSTR;
        end
      end else if (keep) begin
        // Stalled: an empty IF/ID may still take the word; otherwise park it.
        if (!valid_d_q) begin
          valid_d_d = 1'b1;
          instr_d_d = imem_rdata;
          pc_d_d    = pc_req_q;
        end else begin
          pend_push     = 1'b1;
          pend_valid_nx = 1'b1;
        end
      end

      // Only request when the slot is free and nothing will be left waiting for IF/ID.
      issue = (!outstanding || retire) && !pend_valid_nx;
      if (issue) begin
        pc_req_d = pc_f_q;
        pc_f_d   = pc_plus4(pc_f_q);
        state_d  = ST_WAIT;
      end else if (retire) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State, fetch PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_f_q    <= RESET_PC;
      pc_req_q  <= RESET_PC;
      instr_d_q <= NOP_INSTR;
      pc_d_q    <= RESET_PC;
      valid_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      pc_req_q  <= pc_req_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
      valid_d_q <= valid_d_d;
    end
  end

  assign imem_req  = issue && rst_n;
  assign imem_addr = pc_f_q;
  assign InstrD    = instr_d_q;
  assign PCD       = pc_d_q;
  assign PCPlus4D  = pc_plus4(pc_d_q);
  assign ValidD    = valid_d_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        StallD, FlushD, BranchTakenE;
  logic [31:0] BranchTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .InstrD        (InstrD),
    .PCD           (PCD),
    .PCPlus4D      (PCPlus4D),
    .ValidD        (ValidD)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hA5C3_0003;
  endfunction

  // Memory model: one outstanding request, configurable latency.
  int          cyc;
  bit          mem_busy;
  int          mem_due;
  logic [31:0] mem_addr;
  int          lat_lo = 1;
  int          lat_hi = 1;

  // Program-order scoreboard: fetched addresses not yet delivered, with "response seen" flags.
  logic [31:0] q_pc[$];
  bit          q_resp[$];
  logic [31:0] exp_fetch;
  bit          sb_on;
  int          deliveries;
  logic        prev_valid;
  logic [31:0] prev_pcd, prev_instr;
  logic        obs_req;
  logic [31:0] obs_addr;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0; BranchTargetE = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_req", imem_req, 1'b0);
    @(posedge clk);
    #1;
    check("reset_valid", ValidD, 1'b0);
    check("reset_instr", InstrD, NOP);
    check("reset_pcd", PCD, 32'h0);
    check("reset_pcplus4", PCPlus4D, 32'h4);
    mem_busy = 1'b0;
    q_pc.delete();
    q_resp.delete();
    exp_fetch = 32'h0;
    cyc = 0;
    rst_n = 1'b1;
  endtask

  task automatic tick(input bit s, input bit f, input bit b, input logic [31:0] t);
    bit rv;
    @(negedge clk);
    prev_valid = ValidD;
    prev_pcd   = PCD;
    prev_instr = InstrD;
    rv = mem_busy && (cyc >= mem_due);
    StallD = s; FlushD = f; BranchTakenE = b; BranchTargetE = t;
    imem_rvalid = rv;
    imem_rdata  = rv ? tag(mem_addr) : $urandom;
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    if (sb_on) begin
      if (rv) begin
        for (int i = 0; i < q_pc.size(); i++) begin
          if (!q_resp[i] && q_pc[i] == mem_addr) begin
            q_resp[i] = 1'b1;
            break;
          end
        end
      end
      check("one_outstanding", obs_req && mem_busy && !rv, 1'b0);
      if (b) check("no_req_on_branch", obs_req, 1'b0);
      if (obs_req) begin
        check("fetch_addr", obs_addr, exp_fetch);
        q_pc.push_back(obs_addr);
        q_resp.push_back(1'b0);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (b) begin
        q_pc.delete();
        q_resp.delete();
        exp_fetch = t & ~32'd3;
      end else if (f) begin
        while (q_pc.size() > 0 && q_resp[0]) begin
          void'(q_pc.pop_front());
          void'(q_resp.pop_front());
        end
      end
    end
    if (rv) mem_busy = 1'b0;
    if (obs_req) begin
      mem_busy = 1'b1;
      mem_addr = obs_addr;
      mem_due  = cyc + $urandom_range(lat_hi, lat_lo);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (sb_on) begin
      check("pcplus4", PCPlus4D, PCD + 32'd4);
      if (!ValidD) begin
        check("bubble_nop", InstrD, NOP);
      end else if (prev_valid && s && !b && !f) begin
        check("hold_pc", PCD, prev_pcd);
        check("hold_instr", InstrD, prev_instr);
      end else begin
        deliveries++;
        check("deliver_queued", q_pc.size() > 0, 1'b1);
        if (q_pc.size() > 0) begin
          logic [31:0] epc;
          bit          eresp;
          epc   = q_pc.pop_front();
          eresp = q_resp.pop_front();
          check("deliver_resp", eresp, 1'b1);
          check("deliver_pc", PCD, epc);
          check("deliver_instr", InstrD, tag(epc));
        end
      end
    end
  endtask

  typedef struct {
    bit          s;
    bit          rv;
    logic [31:0] rd;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pcd;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(bit s, bit rv, logic [31:0] rd, bit e_req, logic [31:0] e_addr,
                              bit e_valid, logic [31:0] e_pcd, logic [31:0] e_instr);
    vec_t v;
    v.s = s; v.rv = rv; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pcd = e_pcd; v.e_instr = e_instr;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    bit   found;
    int   d0;

    rst_n = 1'b0;
    StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0; BranchTargetE = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    sb_on = 1'b0;
    deliveries = 0;

    // Cycle-by-cycle table: 1-cycle memory, then a 3-cycle stall, then a late response.
    vt[0]  = mk(0, 0, 32'h0,    1, 32'd0,  0, 32'd0,  NOP);
    vt[1]  = mk(0, 1, tag(0),   1, 32'd4,  0, 32'd0,  NOP);
    vt[2]  = mk(0, 1, tag(4),   1, 32'd8,  1, 32'd0,  tag(0));
    vt[3]  = mk(1, 1, tag(8),   0, 32'd0,  1, 32'd4,  tag(4));
    vt[4]  = mk(1, 0, 32'h0,    0, 32'd0,  1, 32'd4,  tag(4));
    vt[5]  = mk(1, 0, 32'h0,    0, 32'd0,  1, 32'd4,  tag(4));
    vt[6]  = mk(0, 0, 32'h0,    1, 32'd12, 1, 32'd4,  tag(4));
    vt[7]  = mk(0, 1, tag(12),  1, 32'd16, 1, 32'd8,  tag(8));
    vt[8]  = mk(0, 1, tag(16),  1, 32'd20, 1, 32'd12, tag(12));
    vt[9]  = mk(0, 0, 32'h0,    0, 32'd0,  1, 32'd16, tag(16));
    vt[10] = mk(0, 1, tag(20),  1, 32'd24, 0, 32'd16, NOP);
    vt[11] = mk(0, 0, 32'h0,    0, 32'd0,  1, 32'd20, tag(20));

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), ValidD, vt[i].e_valid);
      check($sformatf("tbl%0d_pcd", i), PCD, vt[i].e_pcd);
      check($sformatf("tbl%0d_instr", i), InstrD, vt[i].e_instr);
      check($sformatf("tbl%0d_pcplus4", i), PCPlus4D, vt[i].e_pcd + 32'd4);
      StallD = vt[i].s;
      imem_rvalid = vt[i].rv;
      imem_rdata  = vt[i].rd;
      #1;
      check($sformatf("tbl%0d_req", i), imem_req, vt[i].e_req);
      if (vt[i].e_req) check($sformatf("tbl%0d_addr", i), imem_addr, vt[i].e_addr);
    end
    @(negedge clk);
    imem_rvalid = 1'b0;

    // Redirect with a 3-cycle memory while a request is outstanding.
    do_reset();
    sb_on = 1'b1;
    lat_lo = 3; lat_hi = 3;
    repeat (4) tick(0, 0, 0, 32'h0);
    check("br_pre_valid", ValidD, 1'b1);
    check("br_pre_pcd", PCD, 32'h0);
    tick(0, 0, 1, 32'h0000_0103);
    check("br_no_req", obs_req, 1'b0);
    check("br_bubble_valid", ValidD, 1'b0);
    check("br_bubble_instr", InstrD, NOP);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick(0, 0, 0, 32'h0);
      if (obs_req) begin
        found = 1'b1;
        check("br_next_addr", obs_addr, 32'h0000_0100);
      end
    end
    check("br_req_seen", found, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (ValidD) begin
        found = 1'b1;
        check("br_first_pcd", PCD, 32'h0000_0100);
      end else begin
        tick(0, 0, 0, 32'h0);
      end
    end
    check("br_valid_seen", found, 1'b1);

    // Flush while the pending buffer holds a word.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 0, 32'h0);
    tick(1, 0, 0, 32'h0);
    check("fl_stall_no_req", obs_req, 1'b0);
    check("fl_stall_pcd", PCD, 32'h0);
    tick(0, 1, 0, 32'h0);
    check("fl_req", obs_req, 1'b1);
    check("fl_addr", obs_addr, 32'd8);
    check("fl_valid", ValidD, 1'b0);
    check("fl_instr", InstrD, NOP);
    tick(0, 0, 0, 32'h0);
    check("fl_next_valid", ValidD, 1'b1);
    check("fl_next_pcd", PCD, 32'd8);

    // Fetch PC wrap at the top of the address space.
    do_reset();
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 1, 32'hFFFF_FFFC);
    tick(0, 0, 0, 32'h0);
    check("wr_req_top", obs_req, 1'b1);
    check("wr_addr_top", obs_addr, 32'hFFFF_FFFC);
    tick(0, 0, 0, 32'h0);
    check("wr_req_zero", obs_req, 1'b1);
    check("wr_addr_zero", obs_addr, 32'h0);
    check("wr_pcd_top", PCD, 32'hFFFF_FFFC);
    check("wr_pcplus4_zero", PCPlus4D, 32'h0);
    tick(0, 0, 0, 32'h0);
    check("wr_pcd_zero", PCD, 32'h0);

    // Randomized traffic against the scoreboard, then a quiet drain.
    do_reset();
    lat_lo = 1; lat_hi = 3;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      tick(($urandom % 4) == 0, ($urandom % 20) == 0, ($urandom % 20) == 0, tgt);
    end
    d0 = deliveries;
    repeat (40) tick(0, 0, 0, 32'h0);
    check("drain_progress", (deliveries - d0) >= 8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
